// File: rtl/decode_stage.sv
// Decode stage: captures one instruction per valid/ready handshake and presents its
// register indices, class, immediate and write enable to Execute one cycle later.
module decode_stage (
   input  logic        clk,
   input  logic        Rst,
   input  logic [31:0] ins,
   input  logic [15:0] pres_addr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        flush,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [15:0] pc_out,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic [2:0]  funct3,
   output logic        funct7b5,
   output logic [3:0]  cls,
   output logic [31:0] imm,
   output logic [15:0] branoff,
   output logic        rd_we,
   output logic        illegal,
   output logic [15:0] dec_count
);

   typedef enum logic [3:0] {
      CLS_NOP    = 4'd0,
      CLS_LUI    = 4'd1,
      CLS_AUIPC  = 4'd2,
      CLS_JAL    = 4'd3,
      CLS_JALR   = 4'd4,
      CLS_BRANCH = 4'd5,
      CLS_LOAD   = 4'd6,
      CLS_STORE  = 4'd7,
      CLS_OPIMM  = 4'd8,
      CLS_OP     = 4'd9,
      CLS_SYSTEM = 4'd10
   } cls_t;

   logic        accept;
   cls_t        dec_cls;
   logic [31:0] dec_imm;
   logic        dec_we;
   logic        dec_illegal;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   assign imm_i = {{20{ins[31]}}, ins[31:20]};
   assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
   assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
   assign imm_u = {ins[31:12], 12'b0};
   assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

   // Opcodes whose low bits are not 2'b11 never match a case item and fall to illegal.
   always_comb begin
      dec_cls     = CLS_NOP;
      dec_imm     = 32'd0;
      dec_we      = 1'b0;
      dec_illegal = 1'b0;
      case (ins[6:0])
         7'b0110111: begin dec_cls = CLS_LUI;    dec_imm = imm_u; dec_we = 1'b1; end
         7'b0010111: begin dec_cls = CLS_AUIPC;  dec_imm = imm_u; dec_we = 1'b1; end
         7'b1101111: begin dec_cls = CLS_JAL;    dec_imm = imm_j; dec_we = 1'b1; end
         7'b1100111: begin
            if (ins[14:12] == 3'b000) begin
               dec_cls = CLS_JALR;
               dec_imm = imm_i;
               dec_we  = 1'b1;
            end else begin
               dec_illegal = 1'b1;
            end
         end
         7'b1100011: begin dec_cls = CLS_BRANCH; dec_imm = imm_b; end
         7'b0000011: begin dec_cls = CLS_LOAD;   dec_imm = imm_i; dec_we = 1'b1; end
         7'b0100011: begin dec_cls = CLS_STORE;  dec_imm = imm_s; end
         7'b0010011: begin dec_cls = CLS_OPIMM;  dec_imm = imm_i; dec_we = 1'b1; end
         7'b0110011: begin dec_cls = CLS_OP;     dec_we = 1'b1; end
         7'b1110011: begin dec_cls = CLS_SYSTEM; end
         default:    dec_illegal = 1'b1;
      endcase
      // The canonical NOP is reported as class 0 rather than as an OPIMM.
      if (ins == 32'h0000_0013) begin
         dec_cls = CLS_NOP;
         dec_imm = 32'd0;
         dec_we  = 1'b0;
      end
      if (ins[11:7] == 5'd0) begin
         dec_we = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!Rst) begin
         out_valid <= 1'b0;
         pc_out    <= 16'd0;
         rs1       <= 5'd0;
         rs2       <= 5'd0;
         rd        <= 5'd0;
         funct3    <= 3'd0;
         funct7b5  <= 1'b0;
         cls       <= 4'd0;
         imm       <= 32'd0;
         branoff   <= 16'd0;
         rd_we     <= 1'b0;
         illegal   <= 1'b0;
         dec_count <= 16'd0;
      end else begin
         if (flush) begin
            out_valid <= 1'b0;
         end else if (accept) begin
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         // Fields only change on accept, so a stalled output stays put.
         if (accept) begin
            pc_out    <= pres_addr;
            rs1       <= ins[19:15];
            rs2       <= ins[24:20];
            rd        <= ins[11:7];
            funct3    <= ins[14:12];
            funct7b5  <= ins[30];
            cls       <= dec_cls;
            imm       <= dec_imm;
            branoff   <= dec_imm[15:0];
            rd_we     <= dec_we;
            illegal   <= dec_illegal;
            dec_count <= dec_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: expected decodes are queued as instructions
// are driven and compared when the stage presents them.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        Rst;
   logic [31:0] ins;
   logic [15:0] pres_addr;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic        out_ready;
   logic        out_valid;
   logic [15:0] pc_out;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic        funct7b5;
   logic [3:0]  cls;
   logic [31:0] imm;
   logic [15:0] branoff;
   logic        rd_we;
   logic        illegal;
   logic [15:0] dec_count;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk       (clk),
      .Rst       (Rst),
      .ins       (ins),
      .pres_addr (pres_addr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .pc_out    (pc_out),
      .rs1       (rs1),
      .rs2       (rs2),
      .rd        (rd),
      .funct3    (funct3),
      .funct7b5  (funct7b5),
      .cls       (cls),
      .imm       (imm),
      .branoff   (branoff),
      .rd_we     (rd_we),
      .illegal   (illegal),
      .dec_count (dec_count)
   );

   typedef struct packed {
      logic [15:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        f7;
      logic [3:0]  cls;
      logic [31:0] imm;
      logic        we;
      logic        ill;
      logic [15:0] cnt;
   } exp_t;

   exp_t        obs;
   exp_t        e;
   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_count;

   assign obs = {pc_out, rs1, rs2, rd, funct3, funct7b5, cls, imm, rd_we, illegal, dec_count};

   // Reference decoder built from sign-extending casts of the immediate bit fields.
   function automatic exp_t model(input logic [31:0] i, input logic [15:0] a, input logic [15:0] cnt);
      exp_t r;
      logic signed [11:0] s12;
      logic signed [12:0] s13;
      logic signed [20:0] s21;
      r     = '0;
      r.pc  = a;
      r.rs1 = i[19:15];
      r.rs2 = i[24:20];
      r.rd  = i[11:7];
      r.f3  = i[14:12];
      r.f7  = i[30];
      r.cnt = cnt;
      case (i[6:0])
         7'h37: begin r.cls = 4'd1; r.imm = {i[31:12], 12'h000}; r.we = 1'b1; end
         7'h17: begin r.cls = 4'd2; r.imm = {i[31:12], 12'h000}; r.we = 1'b1; end
         7'h6F: begin
            s21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
            r.cls = 4'd3; r.imm = 32'(s21); r.we = 1'b1;
         end
         7'h67: begin
            s12 = i[31:20];
            if (i[14:12] == 3'd0) begin r.cls = 4'd4; r.imm = 32'(s12); r.we = 1'b1; end
            else r.ill = 1'b1;
         end
         7'h63: begin
            s13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
            r.cls = 4'd5; r.imm = 32'(s13);
         end
         7'h03: begin s12 = i[31:20]; r.cls = 4'd6; r.imm = 32'(s12); r.we = 1'b1; end
         7'h23: begin s12 = {i[31:25], i[11:7]}; r.cls = 4'd7; r.imm = 32'(s12); end
         7'h13: begin s12 = i[31:20]; r.cls = 4'd8; r.imm = 32'(s12); r.we = 1'b1; end
         7'h33: begin r.cls = 4'd9; r.we = 1'b1; end
         7'h73: r.cls = 4'd10;
         default: r.ill = 1'b1;
      endcase
      if (i == 32'h0000_0013) begin r.cls = 4'd0; r.imm = 32'd0; r.we = 1'b0; end
      if (r.rd == 5'd0) r.we = 1'b0;
      return r;
   endfunction

   task automatic drive(input logic [31:0] i, input logic [15:0] a, input bit will_accept);
      ins       = i;
      pres_addr = a;
      in_valid  = 1'b1;
      if (will_accept) begin
         exp_count = exp_count + 16'd1;
         sb.push_back(model(i, a, exp_count));
      end
   endtask

   task automatic test_reset();
      Rst = 1'b0; in_valid = 1'b1; ins = 32'h00500093; pres_addr = 16'h0010;
      flush = 1'b1; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
      checks++;
      if (obs !== exp_t'(0) || branoff !== 16'd0) begin
         errors++; $display("[TB] FAIL reset_fields: got %h branoff %h want all zero", obs, branoff);
      end
      Rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_release: in_ready %b out_valid %b want 1 0", in_ready, out_valid);
      end
      exp_count = 16'd0;
      sb.delete();
   endtask

   task automatic test_addi();
      drive(32'h00500093, 16'h0004, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || obs !== e) begin
         errors++; $display("[TB] FAIL addi_model: valid %b got %h want %h", out_valid, obs, e);
      end
      checks++;
      if (cls !== 4'd8 || rd !== 5'd1 || rs1 !== 5'd0 || imm !== 32'd5 || rd_we !== 1'b1 ||
          pc_out !== 16'h0004 || dec_count !== 16'd1) begin
         errors++;
         $display("[TB] FAIL addi_fixed: cls %0d rd %0d rs1 %0d imm %h we %b pc %h cnt %0d want 8 1 0 5 1 0004 1",
                  cls, rd, rs1, imm, rd_we, pc_out, dec_count);
      end
   endtask

   task automatic test_branch();
      drive(32'hFE000EE3, 16'h0008, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("[TB] FAIL beq_model: got %h want %h", obs, e); end
      checks++;
      if (cls !== 4'd5 || imm !== 32'hFFFFFFFC || branoff !== 16'hFFFC || rd_we !== 1'b0) begin
         errors++;
         $display("[TB] FAIL beq_fixed: cls %0d imm %h branoff %h we %b want 5 fffffffc fffc 0",
                  cls, imm, branoff, rd_we);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] prog [11];
      prog = '{32'h123450B7, 32'h00001117, 32'h008000EF, 32'hFFDFF0EF, 32'h000080E7, 32'h00412183,
               32'h00312223, 32'h002081B3, 32'h00000073, 32'h00000013, 32'hFFF00093};
      for (int k = 0; k < 11; k++) begin
         drive(prog[k], 16'h0100 + 16'(4 * k), 1'b1);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (out_valid !== 1'b1 || obs !== e) begin
            errors++; $display("[TB] FAIL b2b_%0d: ins %h valid %b got %h want %h", k, prog[k], out_valid, obs, e);
         end
         if (prog[k][6:0] == 7'h6F) begin
            checks++;
            if (branoff !== e.imm[15:0]) begin
               errors++; $display("[TB] FAIL jal_branoff_%0d: got %h want %h", k, branoff, e.imm[15:0]);
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_stall();
      out_ready = 1'b1;
      drive(32'h000000B7, 16'h0200, 1'b1);
      @(negedge clk);
      out_ready = 1'b0;
      drive(32'h00200113, 16'h0204, 1'b0);
      e = sb[0];
      repeat (3) begin
         #1;
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs !== e) begin
            errors++; $display("[TB] FAIL stall_hold: in_ready %b valid %b got %h want %h", in_ready, out_valid, obs, e);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      e = sb.pop_front();
      checks++;
      if (in_ready !== 1'b1 || obs !== e) begin
         errors++; $display("[TB] FAIL stall_release: in_ready %b got %h want %h", in_ready, obs, e);
      end
      exp_count = exp_count + 16'd1;
      sb.push_back(model(32'h00200113, 16'h0204, exp_count));
      @(negedge clk);
      in_valid = 1'b0;
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || obs !== e) begin
         errors++; $display("[TB] FAIL stall_second: valid %b got %h want %h", out_valid, obs, e);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b1;
      drive(32'h00100093, 16'h0300, 1'b0);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || dec_count !== exp_count) begin
         errors++; $display("[TB] FAIL flush_accept: valid %b cnt %h want 0 %h", out_valid, dec_count, exp_count);
      end
      drive(32'h00300193, 16'h0304, 1'b1);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("[TB] FAIL flush_pre: got %h want %h", obs, e); end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b0 || dec_count !== exp_count) begin
         errors++; $display("[TB] FAIL flush_held: valid %b cnt %h want 0 %h", out_valid, dec_count, exp_count);
      end
   endtask

   task automatic test_illegal();
      logic [31:0] bad [4];
      bad = '{32'hFFFFFFFF, 32'h00001067, 32'h00000000, 32'h0000005B};
      for (int k = 0; k < 4; k++) begin
         drive(bad[k], 16'h0500 + 16'(4 * k), 1'b1);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs !== e || illegal !== 1'b1 || cls !== 4'd0 || rd_we !== 1'b0 || imm !== 32'd0) begin
            errors++; $display("[TB] FAIL illegal_%0d: ins %h got %h want %h", k, bad[k], obs, e);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_stall();
      out_ready = 1'b1;
      drive(32'h00A00513, 16'h0400, 1'b1);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("[TB] FAIL rststall_pre: got %h want %h", obs, e); end
      Rst = 1'b0;
      drive(32'h00B00593, 16'h0404, 1'b0);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || obs !== exp_t'(0)) begin
         errors++; $display("[TB] FAIL rststall_clear: valid %b got %h want 0", out_valid, obs);
      end
      Rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || dec_count !== 16'd0) begin
         errors++; $display("[TB] FAIL rststall_after: valid %b in_ready %b cnt %h", out_valid, in_ready, dec_count);
      end
      exp_count = 16'd0;
      sb.delete();
   endtask

   task automatic test_wrap();
      out_ready = 1'b1;
      drive(32'h00000013, 16'h0600, 1'b0);
      repeat (65535) @(posedge clk);
      @(negedge clk);
      checks++;
      if (dec_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_preload: got %h want ffff", dec_count); end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (dec_count !== 16'h0000 || out_valid !== 1'b1 || cls !== 4'd0 || illegal !== 1'b0) begin
         errors++; $display("[TB] FAIL wrap_rollover: cnt %h valid %b cls %0d ill %b want 0000 1 0 0",
                            dec_count, out_valid, cls, illegal);
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_branch();
      test_back_to_back();
      test_stall();
      test_flush();
      test_illegal();
      test_reset_stall();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: none; all widths fixed (instruction 32 b, address 16 b).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 Rst  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
REQ-004 ins  input  32  instruction word from Fetch.
REQ-005 pres_addr  input  16  byte address of ins.
REQ-006 in_valid  input  1  ins/pres_addr valid this cycle.
REQ-007 in_ready  output  1  stage can accept an instruction this cycle.
REQ-008 flush  input  1  taken branch/jump resolved downstream; discard held instruction.
REQ-009 out_ready  input  1  execute stage accepts output this cycle.
REQ-010 out_valid  output  1  decoded outputs valid.
REQ-011 pc_out  output  16  address of decoded instruction.
REQ-012 rs1, rs2, rd  output  5 each  register indices, ins[19:15], ins[24:20], ins[11:7].
REQ-013 funct3  output  3  ins[14:12]; funct7b5  output  1  ins[30].
REQ-014 cls  output  4  class: 0 NOP/illegal, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BRANCH, 6 LOAD, 7 STORE, 8 OPIMM, 9 OP, 10 SYSTEM.
REQ-015 imm  output  32  sign-extended immediate per class.
REQ-016 branoff  output  16  imm[15:0]; feeds Fetch branch offset.
REQ-017 rd_we  output  1  register write enable.
REQ-018 illegal  output  1  unsupported encoding.
REQ-019 dec_count  output  16  count of instructions accepted.

Function
REQ-020 in_ready SHALL equal (!out_valid || out_ready), combinational, independent of flush.
REQ-021 Accept SHALL occur when in_valid && in_ready && !flush; decoded fields registered, visible next cycle (latency 1).
REQ-022 out_valid next = 0 if flush; else 1 if accept; else 0 if out_ready; else hold.
REQ-023 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-024 flush SHALL win over simultaneous accept; the incoming instruction is dropped and dec_count not incremented.
REQ-025 Opcode ins[6:0]: 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH, 0000011 LOAD, 0100011 STORE, 0010011 OPIMM, 0110011 OP, 1110011 SYSTEM.
REQ-026 Any other opcode, ins[1:0]!=2'b11, or JALR with funct3!=0: illegal=1, cls=0, rd_we=0, imm=0.
REQ-027 Immediates: I {20{i31},i[31:20]}; S {20{i31},i[31:25],i[11:7]}; B {19{i31},i31,i7,i[30:25],i[11:8],0}; U {i[31:12],12'b0}; J {11{i31},i31,i[19:12],i20,i[30:21],0}; OP/SYSTEM imm=0.
REQ-028 rd_we=1 for LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP with rd!=0; else 0.
REQ-029 Instruction 0x00000013 (addi x0,x0,0) SHALL decode cls=0, rd_we=0, illegal=0.
REQ-030 dec_count SHALL increment by 1 per accept, wrap 0xFFFF->0x0000.
REQ-031 branoff SHALL be imm[15:0] truncated, valid for BRANCH and JAL only; other classes undefined-but-registered.

Reset
REQ-032 While Rst=0 at clock edge: out_valid=0, pc_out=0, rs1=rs2=rd=0, funct3=0, funct7b5=0, cls=0, imm=0, branoff=0, rd_we=0, illegal=0, dec_count=0.
REQ-033 Reset SHALL override flush and accept; in_ready SHALL read 1 the cycle after reset release.
REQ-034 Reset asserted mid-stall SHALL discard the held instruction; no output transition beyond reset values.

Verification
REQ-035 Reset, then in_valid=1, ins=0x00500093, pres_addr=0x0004, out_ready=1 -> next cycle out_valid=1, cls=8, rd=1, rs1=0, imm=5, rd_we=1, pc_out=0x0004, dec_count=1.
REQ-036 ins=0xFE000EE3 (beq x0,x0,-4) -> cls=5, imm=0xFFFFFFFC, branoff=0xFFFC, rd_we=0.
REQ-037 out_ready=0 for 3 cycles after accept of ins=0x000000B7 -> outputs stable, in_ready=0, second instruction not accepted; out_ready=1 -> in_ready=1 same cycle.
REQ-038 flush=1 with in_valid=1 -> next cycle out_valid=0, dec_count unchanged.
REQ-039 ins=0xFFFFFFFF -> illegal=1, cls=0, rd_we=0; ins=0x00000067 with funct3=1 variant 0x00001067 -> illegal=1.
REQ-040 Preload dec_count to 0xFFFF via 65535 accepts, one more accept -> dec_count=0x0000.
